// File: rtl/dp_sequencer_if.sv
// Command bus between the instruction/command source and dp_sequencer.
interface dp_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [2:0]       cmd_da;
  logic [2:0]       cmd_aa;
  logic [2:0]       cmd_ba;
  logic [3:0]       cmd_fs;
  logic [15:0]      cmd_imm;
  logic [CNT_W-1:0] cmd_cnt;

  modport master (
    output cmd_valid, cmd_op, cmd_da, cmd_aa, cmd_ba, cmd_fs, cmd_imm, cmd_cnt,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_da, cmd_aa, cmd_ba, cmd_fs, cmd_imm, cmd_cnt,
    output cmd_ready
  );
endinterface

// File: rtl/dp_sequencer.sv
// Expands macro-commands into registered datapath control words (CTRWRD) and
// constant operands (Cin); watches the datapath flags to end DECLOOP.
module dp_sequencer #(
  parameter int CNT_W    = 8,
  parameter int MAX_ITER = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  dp_sequencer_if.slave cmd,
  input  logic        V,
  input  logic        C,
  input  logic        N,
  input  logic        Z,
  output logic [15:0] CTRWRD,
  output logic [15:0] Cin,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [3:0]  flags
);
  localparam int MI_W   = $clog2(MAX_ITER + 1);
  localparam int ITER_W = (CNT_W > MI_W) ? CNT_W : MI_W;

  localparam logic [2:0] OP_NOP  = 3'd0, OP_ALU  = 3'd1, OP_ALUI = 3'd2,
                         OP_LOAD = 3'd3, OP_REP  = 3'd4, OP_MOVE = 3'd5,
                         OP_SWAP = 3'd6, OP_DEC  = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_LOOP} state_t;

  state_t            r_state, w_state_d;
  logic [2:0]        r_op, r_da, r_aa, r_ba;
  logic [3:0]        r_fs;
  logic [CNT_W-1:0]  r_cnt;
  logic [ITER_W-1:0] r_idx, w_idx_d;
  logic [15:0]       r_ctr, w_ctr_d;
  logic [15:0]       r_cin, w_cin_d;
  logic [3:0]        r_flags;

  logic              w_present, w_last, w_to, w_accept;
  logic [ITER_W:0]   w_idx_inc, w_cnt_eff, w_max;

  // Word index only matters for SWAP, which alternates aa/ba roles.
  function automatic logic [15:0] f_word(input logic [2:0] op, input logic [2:0] da,
                                         input logic [2:0] aa, input logic [2:0] ba,
                                         input logic [3:0] fs, input logic [1:0] sidx);
    logic [15:0] w;
    w = 16'h0000;
    case (op)
      OP_ALU, OP_REP: w = {da, aa, ba, 1'b0, fs, 2'b01};
      OP_ALUI:        w = {da, aa, 3'b000, 1'b1, fs, 2'b01};
      OP_LOAD:        w = {da, 3'b000, 3'b000, 1'b0, 4'b0000, 2'b11};
      OP_MOVE:        w = {da, aa, 3'b000, 1'b0, 4'b0000, 2'b01};
      OP_SWAP: begin
        if (aa == ba)        w = 16'h0000;
        else if (sidx == 2'd1) w = {ba, ba, aa, 1'b0, 4'b1010, 2'b01};
        else                 w = {aa, aa, ba, 1'b0, 4'b1010, 2'b01};
      end
      OP_DEC:         w = {da, da, 3'b000, 1'b0, 4'b0110, 2'b01};
      default:        w = 16'h0000;
    endcase
    return w;
  endfunction

  assign w_present = (r_state != S_IDLE);
  assign w_accept  = (r_state == S_IDLE) && cmd.cmd_valid;
  assign w_idx_inc = {1'b0, r_idx} + 1'b1;
  assign w_cnt_eff = (r_cnt == '0) ? (ITER_W+1)'(1) : (ITER_W+1)'(r_cnt);
  assign w_max     = (ITER_W+1)'(MAX_ITER);

  // DECLOOP ends on the Z of the word on the bus, so done is combinational.
  always_comb begin
    w_last = 1'b0;
    w_to   = 1'b0;
    case (r_state)
      S_ISSUE: w_last = (r_op == OP_SWAP && r_aa != r_ba) ? (r_idx == ITER_W'(2)) : 1'b1;
      S_LOOP: begin
        if (r_op == OP_REP) begin
          w_last = (w_idx_inc >= w_cnt_eff);
        end else begin
          w_to   = !Z && (w_idx_inc >= w_max);
          w_last = Z || (w_idx_inc >= w_max);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_ctr_d   = r_ctr;
    w_cin_d   = r_cin;
    case (r_state)
      S_IDLE: begin
        w_ctr_d = 16'h0000;
        w_cin_d = 16'h0000;
        if (w_accept) begin
          w_state_d = (cmd.cmd_op == OP_REP || cmd.cmd_op == OP_DEC) ? S_LOOP : S_ISSUE;
          w_idx_d   = '0;
          w_ctr_d   = f_word(cmd.cmd_op, cmd.cmd_da, cmd.cmd_aa, cmd.cmd_ba, cmd.cmd_fs, 2'd0);
          w_cin_d   = (cmd.cmd_op == OP_ALUI) ? cmd.cmd_imm : 16'h0000;
        end
      end
      default: begin
        if (w_last) begin
          w_state_d = S_IDLE;
          w_ctr_d   = 16'h0000;
          w_cin_d   = 16'h0000;
        end else begin
          w_idx_d = w_idx_inc[ITER_W-1:0];
          w_ctr_d = f_word(r_op, r_da, r_aa, r_ba, r_fs, w_idx_inc[1:0]);
          w_cin_d = 16'h0000;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_ctr   <= 16'h0000;
      r_cin   <= 16'h0000;
      r_flags <= 4'h0;
      r_op    <= 3'd0;
      r_da    <= 3'd0;
      r_aa    <= 3'd0;
      r_ba    <= 3'd0;
      r_fs    <= 4'h0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_ctr   <= w_ctr_d;
      r_cin   <= w_cin_d;
      if (w_present && r_ctr[0]) r_flags <= {V, C, N, Z};
      if (w_accept) begin
        r_op  <= cmd.cmd_op;
        r_da  <= cmd.cmd_da;
        r_aa  <= cmd.cmd_aa;
        r_ba  <= cmd.cmd_ba;
        r_fs  <= cmd.cmd_fs;
        r_cnt <= cmd.cmd_cnt;
      end
    end
  end

  assign cmd.cmd_ready = (r_state == S_IDLE);
  assign CTRWRD        = r_ctr;
  assign Cin           = r_cin;
  assign busy          = w_present;
  assign done          = w_present && w_last;
  assign timeout       = w_present && w_to;
  assign flags         = r_flags;
endmodule

// File: tb/tb_dp_sequencer.sv
// Scoreboard bench: a main DUT on a small register-file/ALU model and a second
// DUT (MAX_ITER=4, Z tied low) for the DECLOOP timeout path.
module tb_dp_sequencer;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] ctr;
    logic [15:0] cin;
    logic        dn;
    logic        to;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   n_chk = 0;
  int   n_fail = 0;

  logic        t_valid = 1'b0, t_sel = 1'b0;
  logic [2:0]  t_op = '0, t_da = '0, t_aa = '0, t_ba = '0;
  logic [3:0]  t_fs = '0;
  logic [15:0] t_imm = '0;
  logic [7:0]  t_cnt = '0;

  dp_sequencer_if #(.CNT_W(8)) if1 ();
  dp_sequencer_if #(.CNT_W(8)) if2 ();

  assign if1.cmd_valid = t_valid & ~t_sel;
  assign if2.cmd_valid = t_valid & t_sel;
  assign if1.cmd_op = t_op;   assign if2.cmd_op = t_op;
  assign if1.cmd_da = t_da;   assign if2.cmd_da = t_da;
  assign if1.cmd_aa = t_aa;   assign if2.cmd_aa = t_aa;
  assign if1.cmd_ba = t_ba;   assign if2.cmd_ba = t_ba;
  assign if1.cmd_fs = t_fs;   assign if2.cmd_fs = t_fs;
  assign if1.cmd_imm = t_imm; assign if2.cmd_imm = t_imm;
  assign if1.cmd_cnt = t_cnt; assign if2.cmd_cnt = t_cnt;

  logic [15:0] CTRWRD, Cin, CTRWRD2, Cin2;
  logic        busy, done, timeout, busy2, done2, timeout2;
  logic [3:0]  flags, flags2;
  logic        V, C, N, Z;

  dp_sequencer #(.CNT_W(8), .MAX_ITER(255)) dut (
    .CLK(CLK), .RESET(RESET), .cmd(if1.slave), .V(V), .C(C), .N(N), .Z(Z),
    .CTRWRD(CTRWRD), .Cin(Cin), .busy(busy), .done(done), .timeout(timeout), .flags(flags)
  );

  dp_sequencer #(.CNT_W(8), .MAX_ITER(4)) dut2 (
    .CLK(CLK), .RESET(RESET), .cmd(if2.slave), .V(1'b0), .C(1'b0), .N(1'b0), .Z(1'b0),
    .CTRWRD(CTRWRD2), .Cin(Cin2), .busy(busy2), .done(done2), .timeout(timeout2), .flags(flags2)
  );

  // Register file + ALU model driven by the main DUT
  logic [15:0] R [8];
  logic [15:0] dp_a, dp_b;
  logic [16:0] dp_f;
  logic        pl_en = 1'b0;
  logic [2:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;

  always_comb begin
    dp_a = R[CTRWRD[12:10]];
    dp_b = CTRWRD[6] ? Cin : R[CTRWRD[9:7]];
    case (CTRWRD[5:2])
      4'b0001: dp_f = {1'b0, dp_a} + 17'd1;
      4'b0010: dp_f = {1'b0, dp_a} + {1'b0, dp_b};
      4'b0110: dp_f = {1'b0, dp_a} - 17'd1;
      4'b1010: dp_f = {1'b0, dp_a ^ dp_b};
      default: dp_f = {1'b0, dp_a};
    endcase
  end
  assign Z = (dp_f[15:0] == 16'h0000);
  assign N = dp_f[15];
  assign C = dp_f[16];
  assign V = 1'b0;

  always @(posedge CLK) begin
    if (pl_en) R[pl_addr] <= pl_data;
    else if (RESET && CTRWRD[0]) R[CTRWRD[15:13]] <= CTRWRD[1] ? 16'h0000 : dp_f[15:0];
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitors: pop one expectation per presented word
  always @(negedge CLK) begin
    if (RESET) begin
      if (busy) begin
        if (q1.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL extra_word: got %h expected none", CTRWRD);
        end else begin
          exp_t e;
          e = q1.pop_front();
          chk("ctrwrd", CTRWRD, e.ctr);
          chk("cin", Cin, e.cin);
          chk("done", {15'd0, done}, {15'd0, e.dn});
          chk("timeout", {15'd0, timeout}, {15'd0, e.to});
        end
      end else begin
        chk("idle_ctrwrd", CTRWRD, 16'h0000);
        chk("idle_cin", Cin, 16'h0000);
        chk("idle_ready", {15'd0, if1.cmd_ready}, 16'd1);
      end
    end
  end

  always @(negedge CLK) begin
    if (RESET && busy2) begin
      if (q2.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL extra_word2: got %h expected none", CTRWRD2);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("ctrwrd2", CTRWRD2, e.ctr);
        chk("done2", {15'd0, done2}, {15'd0, e.dn});
        chk("timeout2", {15'd0, timeout2}, {15'd0, e.to});
      end
    end
  end

  task automatic push1(input logic [15:0] ctr, input logic [15:0] cin, input logic dn, input logic to);
    exp_t e;
    e.ctr = ctr; e.cin = cin; e.dn = dn; e.to = to;
    q1.push_back(e);
  endtask

  task automatic push2(input logic [15:0] ctr, input logic dn, input logic to);
    exp_t e;
    e.ctr = ctr; e.cin = 16'h0; e.dn = dn; e.to = to;
    q2.push_back(e);
  endtask

  task automatic send(input logic sel, input logic [2:0] op, input logic [2:0] da,
                      input logic [2:0] aa, input logic [2:0] ba, input logic [3:0] fs,
                      input logic [15:0] imm, input logic [7:0] cnt);
    int k = 0;
    @(negedge CLK);
    while (!(sel ? if2.cmd_ready : if1.cmd_ready) && k < 50) begin
      @(negedge CLK);
      k++;
    end
    if (!(sel ? if2.cmd_ready : if1.cmd_ready)) begin
      n_chk++; n_fail++;
      $display("FAIL ready_wait: got 0 expected 1");
    end
    t_sel = sel; t_op = op; t_da = da; t_aa = aa; t_ba = ba;
    t_fs = fs; t_imm = imm; t_cnt = cnt; t_valid = 1'b1;
    @(posedge CLK);
    #1 t_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge CLK);
      #1;
      k++;
    end while ((busy || busy2 || q1.size() != 0 || q2.size() != 0) && k < 600);
    n_chk++;
    if (busy || busy2 || q1.size() != 0 || q2.size() != 0) begin
      n_fail++;
      $display("FAIL idle_wait: got busy/pending expected idle");
    end
  endtask

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    @(negedge CLK);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(posedge CLK);
    #1 pl_en = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ctrwrd", CTRWRD, 16'h0);
    chk("rst_cin", Cin, 16'h0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_timeout", {15'd0, timeout}, 16'd0);
    chk("rst_flags", {12'd0, flags}, 16'd0);
    chk("rst_ready", {15'd0, if1.cmd_ready}, 16'd1);
    for (int i = 0; i < 8; i++) preload(3'(i), 16'h0);
    @(negedge CLK) RESET = 1'b1;

    push1(16'h4003, 16'h0, 1'b1, 1'b0);                 // LOAD da=2
    send(0, 3'd3, 3'd2, 3'd0, 3'd0, 4'h0, 16'h0, 8'd0);
    wait_idle();

    push1(16'h2849, 16'h0005, 1'b1, 1'b0);              // ALUI
    send(0, 3'd2, 3'd1, 3'd2, 3'd0, 4'b0010, 16'h0005, 8'd0);
    wait_idle();

    push1(16'h0000, 16'h0, 1'b1, 1'b0);                 // NOP
    send(0, 3'd0, 3'd0, 3'd0, 3'd0, 4'h0, 16'h0, 8'd0);
    push1(16'hE509, 16'h0, 1'b1, 1'b0);                 // ALU da=7 aa=1 ba=2 fs=A+B
    send(0, 3'd1, 3'd7, 3'd1, 3'd2, 4'b0010, 16'h0, 8'd0);
    push1(16'hCC01, 16'h0, 1'b1, 1'b0);                 // MOVE da=6 aa=3
    send(0, 3'd5, 3'd6, 3'd3, 3'd0, 4'h0, 16'h0, 8'd0);
    push1(16'h0000, 16'h0, 1'b1, 1'b0);                 // SWAP aa==ba
    send(0, 3'd6, 3'd0, 3'd2, 3'd2, 4'h0, 16'h0, 8'd0);
    wait_idle();

    preload(3'd3, 16'h1234);
    preload(3'd5, 16'hABCD);
    push1(16'h6EA9, 16'h0, 1'b0, 1'b0);
    push1(16'hB5A9, 16'h0, 1'b0, 1'b0);
    push1(16'h6EA9, 16'h0, 1'b1, 1'b0);
    send(0, 3'd6, 3'd0, 3'd3, 3'd5, 4'h0, 16'h0, 8'd0);
    wait_idle();
    chk("swap_r3", R[3], 16'hABCD);
    chk("swap_r5", R[5], 16'h1234);

    preload(3'd1, 16'h0);
    for (int i = 0; i < 3; i++) push1(16'h2485, 16'h0, (i == 2), 1'b0);
    send(0, 3'd4, 3'd1, 3'd1, 3'd1, 4'b0001, 16'h0, 8'd3);
    wait_idle();
    chk("rep3_r1", R[1], 16'd3);
    push1(16'h2485, 16'h0, 1'b1, 1'b0);
    send(0, 3'd4, 3'd1, 3'd1, 3'd1, 4'b0001, 16'h0, 8'd0);
    wait_idle();
    chk("rep0_r1", R[1], 16'd4);

    preload(3'd4, 16'd3);
    for (int i = 0; i < 3; i++) push1(16'h9019, 16'h0, (i == 2), 1'b0);
    send(0, 3'd7, 3'd4, 3'd0, 3'd0, 4'h0, 16'h0, 8'd0);
    wait_idle();
    chk("dec_r4", R[4], 16'd0);
    chk("dec_flagz", {15'd0, flags[0]}, 16'd1);

    for (int i = 0; i < 4; i++) push2(16'h9019, (i == 3), (i == 3));
    send(1, 3'd7, 3'd4, 3'd0, 3'd0, 4'h0, 16'h0, 8'd0);
    wait_idle();

    // Reset while the second SWAP word is on the bus
    push1(16'h6EA9, 16'h0, 1'b0, 1'b0);
    send(0, 3'd6, 3'd0, 3'd3, 3'd5, 4'h0, 16'h0, 8'd0);
    @(posedge CLK);
    #2 RESET = 1'b0;
    #1;
    chk("midrst_ctrwrd", CTRWRD, 16'h0);
    chk("midrst_cin", Cin, 16'h0);
    chk("midrst_busy", {15'd0, busy}, 16'd0);
    chk("midrst_q", 16'(q1.size()), 16'd0);
    q1.delete();
    @(negedge CLK) RESET = 1'b1;
    #1 chk("post_rst_ready", {15'd0, if1.cmd_ready}, 16'd1);
    push1(16'h4003, 16'h0, 1'b1, 1'b0);
    send(0, 3'd3, 3'd2, 3'd0, 3'd0, 4'h0, 16'h0, 8'd0);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Multi-cycle controller that drives the 16-bit register-file/ALU datapath.
- Accepts macro-commands over a valid/ready handshake and expands each into one or more datapath control words (CTRWRD) plus the constant operand (Cin).
- Samples the datapath status flags V/C/N/Z to terminate loops and report status.
- Sits between the instruction/command source and the datapath; it is the only driver of CTRWRD and Cin.

Parameters:
- CNT_W, 8, width of the repeat-count field cmd_cnt.
- MAX_ITER, 255, maximum number of words a DECLOOP command issues before it aborts with timeout.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  opcode: 0 NOP, 1 ALU, 2 ALUI, 3 LOAD, 4 REP, 5 MOVE, 6 SWAP, 7 DECLOOP.
- cmd_da  in  3  destination register.
- cmd_aa  in  3  A-source register.
- cmd_ba  in  3  B-source register.
- cmd_fs  in  4  ALU function select.
- cmd_imm  in  16  immediate operand.
- cmd_cnt  in  CNT_W  repeat count for REP.
- V, C, N, Z  in  1 each  datapath flags; combinational for the current control word.
- CTRWRD  out  16  control word, registered.
- Cin  out  16  constant operand, registered.
- busy  out  1  a command is executing.
- done  out  1  high during the cycle the last word of a command is presented.
- timeout  out  1  one-cycle pulse with done when DECLOOP hits MAX_ITER.
- flags  out  4  {V,C,N,Z} captured on every issued word with RW=1.

Behaviour:
- Control word layout:
  - DA[15:13], AA[12:10], BA[9:7], MB[6] (1 selects Cin), FS[5:2], MD[1] (1 selects Din), RW[0].
  - FS codes used internally: 0000 pass A, 0001 A+1, 0110 A-1, 1010 XOR.
- Reset (RESET=0, asynchronous): state IDLE; CTRWRD=0, Cin=0, busy=0, done=0, timeout=0, flags=0, cmd_ready=1; all counters cleared. Reset mid-command aborts it immediately with no further words issued.
- States:
  - IDLE: cmd_ready=1, CTRWRD=0 (RW=0, no write).
  - ISSUE: presents words.
  - LOOP: used by REP and DECLOOP.
- Handshake and timing:
  - A command is accepted on a rising edge with cmd_valid & cmd_ready. All cmd_* fields are latched.
  - The first word appears in the next cycle; cmd_ready=0 until the cycle after done.
  - Minimum spacing is 2 cycles per 1-word command.
  - cmd_valid while not ready is ignored and must be held by the source.
- Words per opcode (one word per cycle):
  - NOP: 1 word, CTRWRD=0.
  - ALU: {da,aa,ba,0,fs,0,1}.
  - ALUI: {da,aa,000,1,fs,0,1}; Cin=imm for that cycle.
  - LOAD: {da,000,000,0,0000,1,1}.
  - MOVE: {da,aa,000,0,0000,0,1}.
  - REP: ALU word issued max(cnt,1) times back to back.
  - SWAP (aa, ba): 3 XOR words: aa<-aa^ba, ba<-ba^aa, aa<-aa^ba. If aa==ba, it issues one NOP word instead.
  - DECLOOP: {da,da,000,0,0110,0,1} repeated. Z is sampled at the edge ending each word. It stops when Z=1 or after MAX_ITER words; in the timeout case, timeout=1 with done.
- Cin=0 on every word except ALUI.
- busy=1 from the acceptance edge until the cycle after done. done and timeout are single-cycle pulses.
- flags update at the edge ending any word with RW=1 and hold otherwise.
- The iteration counter is CNT_W-bit / ceil(log2(MAX_ITER+1))-bit and never wraps; reaching the terminal value forces termination.

Test Plan:
- Reset, then LOAD da=2 -> CTRWRD=16'h4003 for exactly 1 cycle with done=1, then 16'h0000; cmd_ready returns 1 the following cycle.
- ALUI da=1 aa=2 fs=0010 imm=16'h0005 -> CTRWRD=16'h2849, Cin=16'h0005 for 1 cycle; Cin=0 afterwards.
- With real datapath, R3=16'h1234, R5=16'hABCD; SWAP aa=3 ba=5 -> words 16'h6EA9, 16'hB5A9, 16'h6EA9; then R3=16'hABCD and R5=16'h1234; done on the third word.
- R1=0; REP da=aa=ba=1 fs=0001 cnt=3 -> 3 consecutive words 16'h2485, R1=3; REP with cnt=0 -> exactly 1 word.
- R4=3; DECLOOP da=4 -> 3 words 16'h9019, R4=0, flags[0]=1, timeout=0. With Z tied 0 and MAX_ITER=4 -> 4 words, done=timeout=1.
- Assert RESET low during the second SWAP word -> CTRWRD, Cin and busy go to 0 immediately. After release, cmd_ready=1 and a new LOAD executes normally.
